// File: rtl/perceptron_train_sequencer_pkg.sv
// Shared types and constants for the perceptron training sequencer.
package perceptron_train_sequencer_pkg;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_TRAIN,
    TS_EVAL,
    TS_FINISH
  } trainer_state_t;

  typedef enum logic [1:0] {
    ACT_SIGMOID,
    ACT_RELU,
    ACT_IDENTITY
  } act_sel_t;

  localparam real DEFAULT_THRESHOLD = 0.5;
  localparam real epsilon = 1.0e-6;

  // Activation used by the Perceptron that this sequencer feeds.
  function automatic real act_func(input real x, input act_sel_t sel);
    real r;
    case (sel)
      ACT_SIGMOID: r = 1.0 / (1.0 + $exp(-x));
      ACT_RELU:    r = (x > 0.0) ? x : 0.0;
      default:     r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/perceptron_train_sequencer_sample.sv
// Training-set storage: max_samples entries of input_units values plus a label.
// One synchronous write port, one combinational read port.
module perceptron_sample_store
  import perceptron_train_sequencer_pkg::*;
#(
  parameter int input_units = 2,
  parameter int max_samples = 8,
  parameter int aw          = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [aw-1:0] wr_addr,
  input  real           wr_values [input_units],
  input  real           wr_expected,
  input  logic [aw-1:0] rd_addr,
  output real           rd_values [input_units],
  output real           rd_expected
);

  real mem_values_q   [max_samples][input_units];
  real mem_expected_q [max_samples];

  // Write one sample; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < input_units; i++) begin
        mem_values_q[wr_addr][i] <= wr_values[i];
      end
      mem_expected_q[wr_addr] <= wr_expected;
    end
  end

  // Asynchronous read of the addressed sample.
  always_comb begin
    for (int i = 0; i < input_units; i++) begin
      rd_values[i] = mem_values_q[rd_addr][i];
    end
    rd_expected = mem_expected_q[rd_addr];
  end

endmodule

// File: rtl/perceptron_train_sequencer.sv
// Epoch/sample scheduler for a single Perceptron: each epoch is one training
// pass over the stored samples followed by one evaluation pass that counts
// correct threshold classifications.
// Optional build macro TRAIN_SEQ_EARLY_STOP_EN: finish as soon as an
// evaluation pass classifies every active sample correctly.
//
// state     | meaning
// TS_IDLE   | waiting for start; storage writable
// TS_TRAIN  | training=1, stepping samples with hold_cycles each
// TS_EVAL   | training=0, stepping samples and counting correct ones
// TS_FINISH | one-cycle done pulse, then back to idle
module perceptron_train_sequencer
  import perceptron_train_sequencer_pkg::*;
#(
  parameter int input_units = 2,
  parameter int max_samples = 8,
  parameter int hold_cycles = 2,
  parameter int epoch_w     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_en,
  input  logic [$clog2(max_samples)-1:0] load_addr,
  input  real                          load_values [input_units],
  input  real                          load_expected,
  input  logic [$clog2(max_samples):0] num_samples,
  input  logic [epoch_w-1:0]           num_epochs,
  input  real                          threshold,
  input  logic                         start,
  input  real                          prediction,
  output real                          values [input_units],
  output real                          expected,
  output logic                         training,
  output logic                         busy,
  output logic                         done,
  output logic [epoch_w-1:0]           epoch_count,
  output logic [$clog2(max_samples):0] correct_count
);

  localparam int AW = $clog2(max_samples);
  localparam int CW = AW + 1;
  localparam int HW = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(hold_cycles - 1);
  localparam logic [CW-1:0] MAX_N     = CW'(max_samples);

  trainer_state_t     state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [CW-1:0]      run_q, run_d;
  logic [CW-1:0]      correct_q, correct_d;
  logic [epoch_w-1:0] epoch_q, epoch_d;
  logic [CW-1:0]      ns_q, ns_d;
  logic [epoch_w-1:0] ne_q, ne_d;
  real                thr_q, thr_d;
  real                values_q [input_units];
  real                values_d [input_units];
  real                expected_q, expected_d;
  logic               training_q, training_d;
  logic               done_q, done_d;

  logic               last_idx;
  logic               sample_ok;
  logic               early_hit;
  logic [CW-1:0]      run_inc;
  logic [epoch_w-1:0] epoch_inc;
  real                rd_values [input_units];
  real                rd_expected;
  logic               store_we;

  assign store_we = load_en && (state_q == TS_IDLE) && !rst;

  perceptron_sample_store #(
    .input_units(input_units),
    .max_samples(max_samples),
    .aw         (AW)
  ) u_store (
    .clk        (clk),
    .wr_en      (store_we),
    .wr_addr    (load_addr),
    .wr_values  (load_values),
    .wr_expected(load_expected),
    .rd_addr    (idx_d),
    .rd_values  (rd_values),
    .rd_expected(rd_expected)
  );

  // Sequencing: sample/hold stepping, pass transitions, epoch and score bookkeeping.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    run_d      = run_q;
    correct_d  = correct_q;
    epoch_d    = epoch_q;
    ns_d       = ns_q;
    ne_d       = ne_q;
    thr_d      = thr_q;
    training_d = 1'b0;
    done_d     = 1'b0;

    last_idx  = ({1'b0, idx_q} == (ns_q - 1'b1));
    // expected_q is the label currently on the output, i.e. the one the
    // Perceptron's prediction refers to.
    sample_ok = ((prediction < thr_q) == (expected_q < thr_q));
    run_inc   = run_q + CW'(sample_ok);
    epoch_inc = epoch_q + 1'b1;
`ifdef TRAIN_SEQ_EARLY_STOP_EN
    early_hit = (run_inc == ns_q);
`else
    early_hit = 1'b0;
`endif

    case (state_q)
      TS_IDLE: begin
        if (start) begin
          ns_d      = (num_samples > MAX_N) ? MAX_N : num_samples;
          ne_d      = num_epochs;
          thr_d     = threshold;
          epoch_d   = '0;
          correct_d = '0;
          run_d     = '0;
          idx_d     = '0;
          hold_d    = HOLD_LAST;
          if ((num_samples == '0) || (num_epochs == '0)) begin
            state_d = TS_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d    = TS_TRAIN;
            training_d = 1'b1;
          end
        end
      end

      TS_TRAIN: begin
        training_d = 1'b1;
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          hold_d = HOLD_LAST;
          if (last_idx) begin
            idx_d      = '0;
            state_d    = TS_EVAL;
            training_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      TS_EVAL: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          hold_d = HOLD_LAST;
          run_d  = run_inc;
          if (last_idx) begin
            idx_d     = '0;
            run_d     = '0;
            correct_d = run_inc;
            epoch_d   = epoch_inc;
            if ((epoch_inc == ne_q) || early_hit) begin
              state_d = TS_FINISH;
              done_d  = 1'b1;
            end else begin
              state_d    = TS_TRAIN;
              training_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      TS_FINISH: begin
        state_d = TS_IDLE;
      end

      default: begin
        state_d = TS_IDLE;
      end
    endcase
  end

  // Next sample presented to the Perceptron; zero whenever no pass is active.
  always_comb begin
    expected_d = 0.0;
    for (int i = 0; i < input_units; i++) begin
      values_d[i] = 0.0;
    end
    if ((state_d == TS_TRAIN) || (state_d == TS_EVAL)) begin
      expected_d = rd_expected;
      for (int i = 0; i < input_units; i++) begin
        values_d[i] = rd_values[i];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TS_IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      run_q      <= '0;
      correct_q  <= '0;
      epoch_q    <= '0;
      ns_q       <= '0;
      ne_q       <= '0;
      thr_q      <= DEFAULT_THRESHOLD;
      expected_q <= 0.0;
      training_q <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < input_units; i++) begin
        values_q[i] <= 0.0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      run_q      <= run_d;
      correct_q  <= correct_d;
      epoch_q    <= epoch_d;
      ns_q       <= ns_d;
      ne_q       <= ne_d;
      thr_q      <= thr_d;
      expected_q <= expected_d;
      training_q <= training_d;
      done_q     <= done_d;
      for (int i = 0; i < input_units; i++) begin
        values_q[i] <= values_d[i];
      end
    end
  end

  // Output mapping.
  always_comb begin
    for (int i = 0; i < input_units; i++) begin
      values[i] = values_q[i];
    end
    expected      = expected_q;
    training      = training_q;
    done          = done_q;
    busy          = (state_q != TS_IDLE);
    epoch_count   = epoch_q;
    correct_count = correct_q;
  end

endmodule
